// File: rtl/usb_rx_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// usb_rx_decoder
//
// Receive-side USB bit decoder. The raw D+/D- pair is synchronised, and a
// bit timer restarts on every line-state change, so the sample point stays
// mid-bit even when the far end's bit timing drifts. Sampled symbols are NRZI
// decoded and checked against the SYNC pattern. After a valid SYNC, stuffed
// bits are removed and the data bits are assembled LSB-first into bytes. The
// decoder then looks for the SE0,SE0,J end-of-packet sequence.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   dplus_in       raw D+ from the bus (asynchronous to clk)
//   dminus_in      raw D- from the bus (asynchronous to clk)
//   rx_data        last completed byte; holds its value until the next byte
//   rx_byte_valid  one-cycle pulse when rx_data has just been updated
//   rx_active      high from the end of a valid SYNC until EOP or error
//   eop            one-cycle pulse when an end-of-packet completes
//   rx_error       one-cycle pulse: bad SYNC, stuff error, SE1, bad or
//                  partial EOP
// ---------------------------------------------------------------------------
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  output logic [7:0] rx_data,
  output logic       rx_byte_valid,
  output logic       rx_active,
  output logic       eop,
  output logic       rx_error
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_SAMPLE = TW'(SAMPLE_POINT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // Line states as {D+, D-}
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_SE0_1 = 3'd3,
    ST_SE0_2 = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Synchroniser and bit-timing signals
  logic          dp_meta_r;
  logic          dp_sync_r;
  logic          dm_meta_r;
  logic          dm_sync_r;
  logic [1:0]    line_s;
  logic [1:0]    line_last_r;
  logic [TW-1:0] timer_r;
  logic          strobe_s;

  // Decoder state, current and next
  state_t        state_r;
  state_t        state_n;
  logic          prev_j_r;
  logic          prev_j_n;
  logic [2:0]    sync_cnt_r;
  logic [2:0]    sync_cnt_n;
  logic [2:0]    bit_cnt_r;
  logic [2:0]    bit_cnt_n;
  logic [2:0]    ones_cnt_r;
  logic [2:0]    ones_cnt_n;
  logic [7:0]    shift_r;
  logic [7:0]    shift_n;
  logic [2:0]    j_run_r;
  logic [2:0]    j_run_n;

  // Output registers, current and next
  logic [7:0]    rx_data_r;
  logic [7:0]    rx_data_n;
  logic          valid_r;
  logic          valid_n;
  logic          active_r;
  logic          active_n;
  logic          eop_r;
  logic          eop_n;
  logic          err_r;
  logic          err_n;

  // Decode helpers for the sampled symbol
  logic          is_j_s;
  logic          is_k_s;
  logic          is_jk_s;
  logic          is_se0_s;
  logic          bit_s;
  logic [7:0]    shifted_s;
  logic          err_hit_s;

  assign line_s    = {dp_sync_r, dm_sync_r};
  assign is_j_s    = (line_s == LS_J);
  assign is_k_s    = (line_s == LS_K);
  assign is_jk_s   = is_j_s | is_k_s;
  assign is_se0_s  = (line_s == LS_SE0);
  // NRZI: no change of J/K from the previous bit decodes as 1
  assign bit_s     = (is_j_s == prev_j_r);
  // LSB-first assembly: new bit enters at the top and moves down
  assign shifted_s = {bit_s, shift_r[7:1]};
  // A strobe is suppressed in the cycle where the line has just moved. The
  // timer is about to restart, so the sample would not be mid-bit.
  assign strobe_s  = (timer_r == TIMER_SAMPLE) && (line_s == line_last_r);

  // Two-flop synchronisers on D+ and D-, reset to the idle J state
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_meta_r <= 1'b1;
      dp_sync_r <= 1'b1;
      dm_meta_r <= 1'b0;
      dm_sync_r <= 1'b0;
    end else begin
      dp_meta_r <= dplus_in;
      dp_sync_r <= dp_meta_r;
      dm_meta_r <= dminus_in;
      dm_sync_r <= dm_meta_r;
    end
  end

  // Bit timer: free-running modulo CLKS_PER_BIT, re-aligned on every line edge
  always_ff @(posedge clk) begin
    if (rst) begin
      line_last_r <= LS_J;
      timer_r     <= '0;
    end else begin
      line_last_r <= line_s;
      if (line_s != line_last_r) begin
        timer_r <= '0;
      end else if (timer_r == TIMER_MAX) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TIMER_ONE;
      end
    end
  end

  // Next-state and datapath decisions, evaluated only on sample strobes
  always_comb begin
    state_n    = state_r;
    prev_j_n   = prev_j_r;
    sync_cnt_n = sync_cnt_r;
    bit_cnt_n  = bit_cnt_r;
    ones_cnt_n = ones_cnt_r;
    shift_n    = shift_r;
    j_run_n    = j_run_r;
    rx_data_n  = rx_data_r;
    active_n   = active_r;
    valid_n    = 1'b0;
    eop_n      = 1'b0;
    err_n      = 1'b0;
    err_hit_s  = 1'b0;

    if (strobe_s) begin
      case (state_r)
        ST_IDLE: begin
          // The first K is the first SYNC bit. It decodes as 0 against idle J.
          if (is_k_s) begin
            state_n    = ST_SYNC;
            prev_j_n   = 1'b0;
            sync_cnt_n = 3'd1;
          end else begin
            state_n = ST_IDLE;
          end
        end

        ST_SYNC: begin
          if (is_jk_s) begin
            prev_j_n = is_j_s;
            if (sync_cnt_r == 3'd7) begin
              if (bit_s) begin
                state_n    = ST_DATA;
                active_n   = 1'b1;
                ones_cnt_n = 3'd1;  // the SYNC's trailing 1 starts the run
                bit_cnt_n  = 3'd0;
              end else begin
                err_hit_s = 1'b1;
              end
            end else if (!bit_s) begin
              sync_cnt_n = sync_cnt_r + 3'd1;
            end else begin
              err_hit_s = 1'b1;
            end
          end else begin
            err_hit_s = 1'b1;
          end
        end

        ST_DATA: begin
          if (is_jk_s) begin
            prev_j_n = is_j_s;
            if (ones_cnt_r == 3'd6) begin
              // Stuff check precedes byte completion; a stuffed 0 is dropped
              // and never advances bit_cnt.
              if (bit_s) begin
                err_hit_s = 1'b1;
              end else begin
                ones_cnt_n = 3'd0;
              end
            end else begin
              shift_n    = shifted_s;
              ones_cnt_n = bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
              bit_cnt_n  = bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rx_data_n = shifted_s;
                valid_n   = 1'b1;
              end else begin
                rx_data_n = rx_data_r;
              end
            end
          end else if (is_se0_s) begin
            state_n = ST_SE0_1;
          end else begin
            err_hit_s = 1'b1;
          end
        end

        ST_SE0_1: begin
          if (is_se0_s) begin
            state_n = ST_SE0_2;
          end else begin
            err_hit_s = 1'b1;
          end
        end

        ST_SE0_2: begin
          if (is_j_s) begin
            state_n  = ST_IDLE;
            active_n = 1'b0;
            eop_n    = 1'b1;
            // A partially assembled byte is dropped and flagged with the EOP
            err_n    = (bit_cnt_r != 3'd0);
          end else begin
            err_hit_s = 1'b1;
          end
        end

        ST_ERR: begin
          // Seven consecutive J samples return the decoder to idle. Any other
          // symbol, SE0 included, restarts the count.
          if (is_j_s) begin
            if (j_run_r == 3'd6) begin
              state_n = ST_IDLE;
              j_run_n = 3'd0;
            end else begin
              j_run_n = j_run_r + 3'd1;
            end
          end else begin
            j_run_n = 3'd0;
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end

    // Common error exit; it also cancels any byte strobe raised by this sample
    if (err_hit_s) begin
      state_n  = ST_ERR;
      active_n = 1'b0;
      err_n    = 1'b1;
      valid_n  = 1'b0;
      j_run_n  = 3'd0;
    end else begin
      j_run_n = j_run_n;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Decoder datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_j_r   <= 1'b1;
      sync_cnt_r <= 3'd0;
      bit_cnt_r  <= 3'd0;
      ones_cnt_r <= 3'd0;
      shift_r    <= 8'h00;
      j_run_r    <= 3'd0;
    end else begin
      prev_j_r   <= prev_j_n;
      sync_cnt_r <= sync_cnt_n;
      bit_cnt_r  <= bit_cnt_n;
      ones_cnt_r <= ones_cnt_n;
      shift_r    <= shift_n;
      j_run_r    <= j_run_n;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r <= 8'h00;
      valid_r   <= 1'b0;
      active_r  <= 1'b0;
      eop_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rx_data_r <= rx_data_n;
      valid_r   <= valid_n;
      active_r  <= active_n;
      eop_r     <= eop_n;
      err_r     <= err_n;
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_byte_valid = valid_r;
  assign rx_active     = active_r;
  assign eop           = eop_r;
  assign rx_error      = err_r;

endmodule

// File: tb/tb_usb_rx_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for usb_rx_decoder. The stimulus tasks act as a small
// NRZI/bit-stuffing transmitter. Before a packet is sent, the events it should
// produce are queued. A monitor checks every output pulse against that queue.
module tb_usb_rx_decoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  // Event codes: {rx_byte_valid, eop, rx_error}
  localparam logic [2:0] EV_BYTE    = 3'b100;
  localparam logic [2:0] EV_ERR     = 3'b001;
  localparam logic [2:0] EV_EOP     = 3'b010;
  localparam logic [2:0] EV_EOP_ERR = 3'b011;

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       dplus_in;
  logic       dminus_in;
  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_active;
  logic       eop;
  logic       rx_error;

  exp_t       exp_q[$];
  int         n_run  = 0;
  int         n_fail = 0;

  logic [1:0] tx_line;
  int         ones;
  bit         jitter_en = 1'b0;
  int         jit_idx   = 0;

  usb_rx_decoder #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .dplus_in      (dplus_in),
    .dminus_in     (dminus_in),
    .rx_data       (rx_data),
    .rx_byte_valid (rx_byte_valid),
    .rx_active     (rx_active),
    .eop           (eop),
    .rx_error      (rx_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the next queued expectation
  always @(negedge clk) begin : monitor
    logic [2:0] got;
    exp_t       e;
    got = {rx_byte_valid, eop, rx_error};
    if (got != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", 32'(got), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event_kind", 32'(got), 32'(e.code));
        if (e.code[2]) begin
          check_eq("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
    end
  end

  task automatic expect_ev(input logic [2:0] code, input logic [7:0] data);
    exp_t e;
    e.code = code;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Bit length: 8 clk nominal; with jitter, cycle 8,9,7 so drift stays within 1 clk
  task automatic next_len(output int n);
    if (jitter_en) begin
      n = (jit_idx == 0) ? 8 : ((jit_idx == 1) ? 9 : 7);
      jit_idx = (jit_idx + 1) % 3;
    end else begin
      n = 8;
    end
  endtask

  task automatic send_sym(input logic [1:0] ls);
    int n;
    next_len(n);
    {dplus_in, dminus_in} = ls;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nrzi(input bit b);
    if (!b) tx_line = (tx_line == J) ? K : J;
    send_sym(tx_line);
  endtask

  task automatic send_sync();
    tx_line = J;
    for (int i = 0; i < 7; i++) send_nrzi(1'b0);
    send_nrzi(1'b1);
    ones = 1;
  endtask

  task automatic send_data_bit(input bit b, input bit stuff_en);
    send_nrzi(b);
    ones = b ? ones + 1 : 0;
    if (stuff_en && ones == 6) begin
      send_nrzi(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(d[i], 1'b1);
  endtask

  task automatic send_eop();
    send_sym(SE0);
    send_sym(SE0);
    send_sym(J);
    tx_line = J;
  endtask

  task automatic idle(input int nbits);
    tx_line = J;
    for (int i = 0; i < nbits; i++) send_sym(J);
  endtask

  task automatic end_test(input string name);
    idle(12);
    check_eq({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    {dplus_in, dminus_in} = J;
    tx_line = J;
    ones = 0;
    repeat (4) @(negedge clk);
    check_eq("reset_rx_data", 32'(rx_data), 32'h00);
    check_eq("reset_pulses", 32'({rx_byte_valid, eop, rx_error, rx_active}), 32'd0);
    rst = 1'b0;
    idle(4);

    // 1: SYNC + 0xA5 + EOP
    expect_ev(EV_BYTE, 8'hA5);
    expect_ev(EV_EOP, 8'h00);
    send_sync();
    check_eq("t1_active_after_sync", 32'(rx_active), 32'd1);
    send_byte(8'hA5);
    send_eop();
    check_eq("t1_active_after_eop", 32'(rx_active), 32'd0);
    end_test("t1");

    // 2: 0xFF,0xFF with stuffed zeros after each run of six ones
    expect_ev(EV_BYTE, 8'hFF);
    expect_ev(EV_BYTE, 8'hFF);
    expect_ev(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_eop();
    end_test("t2");

    // 3: unstuffed ones. The SYNC's trailing 1 counts, so the 6th data one
    // is the seventh consecutive 1 on the wire.
    expect_ev(EV_ERR, 8'h00);
    send_sync();
    for (int i = 0; i < 3; i++) send_data_bit(1'b1, 1'b0);
    check_eq("t3_active_mid", 32'(rx_active), 32'd1);
    for (int i = 0; i < 4; i++) send_data_bit(1'b1, 1'b0);
    check_eq("t3_active_after_err", 32'(rx_active), 32'd0);
    end_test("t3");

    // 4: corrupt SYNC, then a good 0x3C packet
    expect_ev(EV_ERR, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send_sym((i % 2 == 0) ? K : J);
      check_eq("t4_active_low", 32'(rx_active), 32'd0);
    end
    idle(10);
    expect_ev(EV_BYTE, 8'h3C);
    expect_ev(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'h3C);
    send_eop();
    end_test("t4");

    // 5: 0x5A then 3 stray bits then EOP -> eop and rx_error together
    expect_ev(EV_BYTE, 8'h5A);
    expect_ev(EV_EOP_ERR, 8'h00);
    send_sync();
    send_byte(8'h5A);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_eop();
    check_eq("t5_rx_data_hold", 32'(rx_data), 32'h5A);
    end_test("t5");

    // 6: reset mid-byte, then a jittered 0xC3 packet
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(1'b1, 1'b1);
    check_eq("t6_active_pre_rst", 32'(rx_active), 32'd1);
    {dplus_in, dminus_in} = J;
    tx_line = J;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_rst_rx_data", 32'(rx_data), 32'h00);
    check_eq("t6_rst_outputs", 32'({rx_byte_valid, eop, rx_error, rx_active}), 32'd0);
    jitter_en = 1'b1;
    idle(4);
    expect_ev(EV_BYTE, 8'hC3);
    expect_ev(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hC3);
    send_eop();
    end_test("t6");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
